// File: rtl/ssf_bus_master_if.sv
// Host request/response handshake and 68K-style cartridge bus of the
// ssf_bus_master. The master modport is the bus-master side (the DUT);
// the slave modport is the host plus cartridge responder side.
interface ssf_bus_master_if;
  // Request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [22:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  // Response channel
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  // Cartridge bus
  logic [22:0] cart_address;
  logic [15:0] cart_data_out;
  logic        cart_data_oe;
  logic [15:0] cart_data_in;
  logic        as;
  logic        lwr;
  logic        uwr;
  logic        cas0;
  logic        cas2;
  logic        ceo;
  logic        asel;
  logic        tme;
  logic        dtack;

  modport master (
    input  req_valid, req_write, req_addr, req_be, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_timeout,
    output cart_address, cart_data_out, cart_data_oe,
    input  cart_data_in,
    output as, lwr, uwr, cas0, cas2, ceo, asel, tme,
    input  dtack
  );

  modport slave (
    output req_valid, req_write, req_addr, req_be, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_timeout,
    input  cart_address, cart_data_out, cart_data_oe,
    output cart_data_in,
    input  as, lwr, uwr, cas0, cas2, ceo, asel, tme,
    output dtack
  );
endinterface

// File: rtl/ssf_bus_master.sv
// Single-transfer 68K-style cartridge bus master.
//
// Handshake: a request transfers on a rising vclk edge where req_valid and
// req_ready are both high; req_ready is high only while the FSM is idle.
// The response is a single-cycle rsp_valid pulse with no back-pressure;
// rsp_rdata and rsp_timeout stay stable until the next response pulse.
//
// Bus cycle: SETUP (address + selects valid, strobes low) -> STROBE (as high,
// write strobes per byte enable, wait for dtack or timeout) -> HOLD (strobes
// low, address/data still driven) -> RESP (one-cycle response) -> IDLE.
module ssf_bus_master #(
  parameter int SETUP_CYC = 1,
  parameter int HOLD_CYC  = 1,
  parameter int TIMEOUT   = 15
) (
  input  logic                  vclk,
  input  logic                  vres,
  ssf_bus_master_if.master      bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Terminal counts for the per-state cycle counter.
  localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;

  // Registered copy of the accepted request; drives the bus for the cycle.
  logic [22:0] addr_q;
  logic        write_q;
  logic [1:0]  be_q;
  logic [15:0] wdata_q;

  // Result of the strobe phase, published to the response outputs in RESP
  // so the previous response stays stable throughout the next bus cycle.
  logic [15:0] rdata_q;
  logic        timeout_q;

  // Registered outputs.
  logic        ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_rdata_q;
  logic        rsp_timeout_q;
  logic        oe_q;
  logic        as_q;
  logic        lwr_q;
  logic        uwr_q;

  // Bus-cycle FSM with all control outputs registered alongside the state.
  always_ff @(posedge vclk) begin
    if (vres) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      be_q          <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      timeout_q     <= 1'b0;
      ready_q       <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      oe_q          <= 1'b0;
      as_q          <= 1'b0;
      lwr_q         <= 1'b0;
      uwr_q         <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            write_q <= bus.req_write;
            be_q    <= bus.req_be;
            wdata_q <= bus.req_wdata;
            oe_q    <= bus.req_write;
            ready_q <= 1'b0;
            cnt     <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt   <= '0;
            as_q  <= 1'b1;
            // Write strobes follow the byte enables; reads never pulse them.
            lwr_q <= write_q & be_q[0];
            uwr_q <= write_q & be_q[1];
            state <= STROBE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        STROBE: begin
          if (bus.dtack) begin
            timeout_q <= 1'b0;
            if (!write_q) rdata_q <= bus.cart_data_in;
            cnt   <= '0;
            as_q  <= 1'b0;
            lwr_q <= 1'b0;
            uwr_q <= 1'b0;
            state <= HOLD;
          end else if (cnt == TIMEOUT_LAST) begin
            // No responder: finish the cycle and report all-ones read data.
            timeout_q <= 1'b1;
            if (!write_q) rdata_q <= 16'hFFFF;
            cnt   <= '0;
            as_q  <= 1'b0;
            lwr_q <= 1'b0;
            uwr_q <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt           <= '0;
            oe_q          <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= rdata_q;
            rsp_timeout_q <= timeout_q;
            state         <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          oe_q    <= 1'b0;
          as_q    <= 1'b0;
          lwr_q   <= 1'b0;
          uwr_q   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Output wiring: request/response handshake.
  assign bus.req_ready   = ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  // Output wiring: cartridge bus driven from the captured request.
  assign bus.cart_address  = addr_q;
  assign bus.cart_data_out = wdata_q;
  assign bus.cart_data_oe  = oe_q;
  assign bus.as            = as_q;
  assign bus.lwr           = lwr_q;
  assign bus.uwr           = uwr_q;

  // Region decodes on the byte address {addr_q, 1'b0}; word bit n is byte
  // bit n+1, so the byte-address thresholds reduce to top-bit compares.
  assign bus.cas2 = (addr_q[22:20] == 3'b111);        // >= $E00000
  assign bus.cas0 = ~(addr_q[22:20] == 3'b111);       //  < $E00000
  assign bus.ceo  = (addr_q[22:21] == 2'b00);         //  < $400000
  assign bus.asel = ~addr_q[22];                      //  < $800000
  assign bus.tme  = (addr_q[22:7] == 16'hA130);       // $A130xx

  assign dbg_state = state;

endmodule

// File: tb/tb_ssf_bus_master.sv
// Directed testbench for ssf_bus_master with default parameters
// (SETUP_CYC = 1, HOLD_CYC = 1, TIMEOUT = 15).
module tb_ssf_bus_master;

  logic       vclk;
  logic       vres;
  logic [2:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;

  ssf_bus_master_if bus ();

  ssf_bus_master dut (
    .vclk      (vclk),
    .vres      (vres),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial vclk = 1'b0;
  always #5 vclk = ~vclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Response pulse monitor, sampled away from the active edge.
  logic mon_en = 1'b0;
  int   pulse_cnt = 0;
  always @(negedge vclk) if (mon_en && bus.rsp_valid === 1'b1) pulse_cnt++;

  // One clock: wait for the edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge vclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic valid, input logic write, input logic [22:0] addr,
                         input logic [1:0] be, input logic [15:0] wdata);
    bus.req_valid = valid;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_be    = be;
    bus.req_wdata = wdata;
  endtask

  int as_cnt;
  int got_rsp;
  int stray;

  initial begin
    vres = 1'b1;
    set_req(1'b0, 1'b0, 23'h0, 2'b00, 16'h0);
    bus.cart_data_in = 16'h0;
    bus.dtack        = 1'b0;

    // ---------------- reset state ----------------
    step(); step(); step();
    chk("rst_ready",   32'(bus.req_ready), 1);
    chk("rst_rvalid",  32'(bus.rsp_valid), 0);
    chk("rst_rtmo",    32'(bus.rsp_timeout), 0);
    chk("rst_rdata",   32'(bus.rsp_rdata), 0);
    chk("rst_addr",    32'(bus.cart_address), 0);
    chk("rst_dout",    32'(bus.cart_data_out), 0);
    chk("rst_oe",      32'(bus.cart_data_oe), 0);
    chk("rst_strobes", 32'({bus.as, bus.lwr, bus.uwr}), 0);
    chk("rst_decodes", 32'({bus.cas0, bus.ceo, bus.asel, bus.cas2, bus.tme}), 'b11100);
    chk("rst_state",   32'(dbg_state), 0);
    vres = 1'b0;
    step();

    // ---------------- bank write, dtack high from the start ----------------
    bus.dtack = 1'b1;
    set_req(1'b1, 1'b1, 23'h509879, 2'b01, 16'h0005);
    step(); // accept edge 0 -> SETUP
    bus.req_valid = 1'b0;
    chk("bw_setup_state", 32'(dbg_state), 1);
    chk("bw_setup_ready", 32'(bus.req_ready), 0);
    chk("bw_setup_as",    32'({bus.as, bus.lwr, bus.uwr}), 0);
    chk("bw_setup_oe",    32'(bus.cart_data_oe), 1);
    chk("bw_setup_addr",  32'(bus.cart_address), 'h509879);
    step(); // edge 1 -> STROBE
    chk("bw_strobe_state", 32'(dbg_state), 2);
    chk("bw_strobe_as",    32'(bus.as), 1);
    chk("bw_strobe_lwr",   32'(bus.lwr), 1);
    chk("bw_strobe_uwr",   32'(bus.uwr), 0);
    chk("bw_strobe_dout",  32'(bus.cart_data_out), 'h0005);
    chk("bw_strobe_dec",   32'({bus.tme, bus.cas0, bus.ceo, bus.asel, bus.cas2}), 'b11000);
    step(); // edge 2 -> HOLD
    chk("bw_hold_strobes", 32'({bus.as, bus.lwr, bus.uwr}), 0);
    chk("bw_hold_oe",      32'(bus.cart_data_oe), 1);
    chk("bw_hold_addr",    32'(bus.cart_address), 'h509879);
    chk("bw_hold_dout",    32'(bus.cart_data_out), 'h0005);
    chk("bw_hold_rvalid",  32'(bus.rsp_valid), 0);
    step(); // edge 3 -> RESP (4th cycle)
    chk("bw_resp_rvalid", 32'(bus.rsp_valid), 1);
    chk("bw_resp_rtmo",   32'(bus.rsp_timeout), 0);
    chk("bw_resp_oe",     32'(bus.cart_data_oe), 0);
    step(); // edge 4 -> IDLE
    chk("bw_idle_rvalid", 32'(bus.rsp_valid), 0);
    chk("bw_idle_ready",  32'(bus.req_ready), 1);

    // ---------------- ROM read, dtack raised in 3rd STROBE cycle ----------------
    bus.dtack        = 1'b0;
    bus.cart_data_in = 16'h4E71;
    set_req(1'b1, 1'b0, 23'h000100, 2'b11, 16'hDEAD);
    step(); // edge 0
    bus.req_valid = 1'b0;
    chk("rd_setup_oe",   32'({bus.cart_data_oe, bus.lwr, bus.uwr}), 0);
    chk("rd_setup_addr", 32'(bus.cart_address), 'h000100);
    step(); // edge 1: STROBE cycle 1
    chk("rd_s1", 32'({bus.as, bus.lwr, bus.uwr, bus.cart_data_oe}), 'b1000);
    chk("rd_dec", 32'({bus.cas0, bus.ceo, bus.asel, bus.cas2, bus.tme}), 'b11100);
    step(); // edge 2: STROBE cycle 2
    chk("rd_s2", 32'({bus.as, bus.lwr, bus.uwr, bus.cart_data_oe}), 'b1000);
    step(); // edge 3: STROBE cycle 3
    chk("rd_s3", 32'({bus.as, bus.lwr, bus.uwr, bus.cart_data_oe}), 'b1000);
    bus.dtack = 1'b1;
    step(); // edge 4: HOLD
    chk("rd_hold", 32'({bus.as, bus.lwr, bus.uwr, bus.cart_data_oe}), 'b0000);
    chk("rd_hold_rdata_kept", 32'(bus.rsp_rdata), 0);
    step(); // edge 5: RESP
    chk("rd_resp_rvalid", 32'(bus.rsp_valid), 1);
    chk("rd_resp_rdata",  32'(bus.rsp_rdata), 'h4E71);
    chk("rd_resp_rtmo",   32'(bus.rsp_timeout), 0);
    chk("rd_resp_pins",   32'({bus.lwr, bus.uwr, bus.cart_data_oe}), 0);
    step(); // edge 6: IDLE
    chk("rd_idle_rdata",  32'(bus.rsp_rdata), 'h4E71);

    // ---------------- timeout read at $E00000 ----------------
    bus.dtack = 1'b0;
    set_req(1'b1, 1'b0, 23'h700000, 2'b11, 16'h0);
    step(); // edge 0
    bus.req_valid = 1'b0;
    step(); // edge 1: STROBE
    chk("to_dec", 32'({bus.cas2, bus.cas0, bus.ceo, bus.asel, bus.tme}), 'b10000);
    chk("to_rdata_kept", 32'(bus.rsp_rdata), 'h4E71);
    as_cnt  = (bus.as === 1'b1) ? 1 : 0;
    got_rsp = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.as === 1'b1) as_cnt++;
      if (bus.rsp_valid === 1'b1) begin
        got_rsp = 1;
        break;
      end
    end
    chk("to_got_rsp", 32'(got_rsp), 1);
    chk("to_as_cycles", 32'(as_cnt), 15);
    chk("to_rtmo",  32'(bus.rsp_timeout), 1);
    chk("to_rdata", 32'(bus.rsp_rdata), 'hFFFF);
    step();
    chk("to_hold_vals", 32'({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata}), 'h1FFFF);

    // ---------------- write with no byte enables ----------------
    bus.dtack = 1'b1;
    set_req(1'b1, 1'b1, 23'h000040, 2'b00, 16'h1234);
    step(); // edge 0
    bus.req_valid = 1'b0;
    step(); // edge 1: STROBE
    chk("be0_strobe", 32'({bus.as, bus.lwr, bus.uwr, bus.cart_data_oe}), 'b1001);
    step(); // edge 2: HOLD
    step(); // edge 3: RESP
    chk("be0_resp", 32'({bus.rsp_valid, bus.rsp_timeout}), 'b10);
    step(); // IDLE

    // ---------------- reset in 2nd STROBE cycle of a write ----------------
    bus.dtack = 1'b0;
    set_req(1'b1, 1'b1, 23'h000800, 2'b01, 16'hABCD);
    step(); // edge 0
    bus.req_valid = 1'b0;
    step(); // edge 1: STROBE cycle 1
    chk("mr_s1", 32'({bus.as, bus.lwr}), 'b11);
    step(); // edge 2: STROBE cycle 2
    chk("mr_s2", 32'({bus.as, bus.lwr}), 'b11);
    vres = 1'b1;
    step(); // edge 3: reset
    chk("mr_strobes", 32'({bus.as, bus.lwr, bus.uwr}), 0);
    chk("mr_ready",   32'(bus.req_ready), 1);
    chk("mr_rvalid",  32'(bus.rsp_valid), 0);
    chk("mr_bus",     32'({bus.cart_data_oe, bus.cart_address}), 0);
    vres = 1'b0;
    bus.dtack = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.rsp_valid === 1'b1) stray++;
    end
    chk("mr_no_rsp", 32'(stray), 0);

    // ---------------- back-to-back writes, req_valid held ----------------
    pulse_cnt = 0;
    mon_en    = 1'b1;
    set_req(1'b1, 1'b1, 23'h000010, 2'b11, 16'h1111);
    step(); // edge 0: first accepted
    set_req(1'b1, 1'b1, 23'h123456, 2'b11, 16'h2222);
    step(); // edge 1
    chk("bb_a1", 32'(bus.cart_address), 'h000010);
    step(); // edge 2
    step(); // edge 3: RESP of first
    chk("bb_rsp1", 32'(bus.rsp_valid), 1);
    step(); // edge 4: IDLE
    chk("bb_idle", 32'({bus.as, bus.req_ready, bus.rsp_valid}), 'b010);
    step(); // edge 5: second accepted
    bus.req_valid = 1'b0;
    chk("bb_acc2", 32'({bus.as, bus.req_ready}), 'b00);
    chk("bb_addr2_setup", 32'(bus.cart_address), 'h123456);
    step(); // edge 6: STROBE
    chk("bb_strobe2", 32'({bus.as, bus.lwr, bus.uwr}), 'b111);
    chk("bb_addr2", 32'(bus.cart_address), 'h123456);
    chk("bb_dout2", 32'(bus.cart_data_out), 'h2222);
    step(); // edge 7
    step(); // edge 8: RESP of second
    chk("bb_rsp2", 32'(bus.rsp_valid), 1);
    step(); step(); step(); step();
    mon_en = 1'b0;
    chk("bb_pulses", 32'(pulse_cnt), 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
